// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for a 5-stage in-order pipeline. It drives the enable
//   and synchronous-clear pins of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers and the PC enable. It resolves three hazard sources:
//   load-use dependencies, taken control redirects, and multi-cycle EX
//   operations.
//
// Ports
//   clk          core clock; all state updates on the rising edge
//   reset        synchronous, active-high; while high, every pipeline
//                register is enabled and cleared, and the PC is held
//   load_use     the instruction in ID depends on a load in EX
//   redirect     a branch/jump resolved taken in EX; the PC is being redirected
//   mc_start     the instruction in EX is multi-cycle (first EX cycle)
//   pc_en        PC register enable
//   if_id_en     IF/ID enable;   if_id_flush   IF/ID clear (only with en=1)
//   id_ex_en     ID/EX enable;   id_ex_flush   ID/EX clear
//   ex_mem_en    EX/MEM enable;  ex_mem_flush  EX/MEM clear
//   mem_wb_en    MEM/WB enable
//   mc_busy      a multi-cycle operation is occupying EX
//   stall_cnt    saturating count of cycles with pc_en=0 (excluding reset)
module pipe_hazard_ctrl #(
  parameter int MC_LATENCY  = 4,
  parameter int CNT_W       = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_use,
  input  logic                   redirect,
  input  logic                   mc_start,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_en,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   ex_mem_flush,
  output logic                   mem_wb_en,
  output logic                   mc_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE,
    MC_BUSY
  } state_t;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MC_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic release_cycle;
  logic busy_hold;
  logic mc_accept;
  logic mc_stall;

  // cnt==1 in MC_BUSY is the release cycle: EX/MEM captures the result and
  // the controller behaves as in IDLE, except that mc_start is ignored.
  assign release_cycle = (state == MC_BUSY) && (cnt == CNT_ONE);
  assign busy_hold     = (state == MC_BUSY) && (cnt != CNT_ONE);
  // A single-cycle "multi-cycle" op needs no stall at all.
  assign mc_accept     = (state == IDLE) && mc_start && !redirect && (MC_LATENCY > 1);
  assign mc_stall      = busy_hold || mc_accept;

  // State register, latency counter and stall performance counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (!pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (mc_accept) begin
          state_next = MC_BUSY;
          cnt_next   = LAT_M1;
        end
      end
      MC_BUSY: begin
        if (release_cycle) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic; the idle and release cycles share the priority chain, with
  // mc_start already masked out of mc_accept outside IDLE.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;
    mc_busy      = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      mc_busy = (state == MC_BUSY);
      if (mc_stall) begin
        // Freeze the front end and push a bubble into MEM while EX is occupied.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: two instances (default parameters, and a
// 2-bit saturating stall counter with MC_LATENCY=1) driven with the same
// directed and random stimulus, compared each cycle against a reference model.
module tb_pipe_hazard_ctrl;

  localparam int LAT_A = 4;
  localparam int W_A   = 16;
  localparam int LAT_B = 1;
  localparam int W_B   = 2;

  logic clk = 1'b0;
  logic reset, load_use, redirect, mc_start;

  logic a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_en, a_id_ex_flush;
  logic a_ex_mem_en, a_ex_mem_flush, a_mem_wb_en, a_mc_busy;
  logic [W_A-1:0] a_stall_cnt;

  logic b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_flush;
  logic b_ex_mem_en, b_ex_mem_flush, b_mem_wb_en, b_mc_busy;
  logic [W_B-1:0] b_stall_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state: busy cycles still to come and stall count
  int a_left = 0, a_stall = 0;
  int b_left = 0, b_stall = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MC_LATENCY(LAT_A), .CNT_W(3), .STALL_CNT_W(W_A)) dut_a (
    .clk(clk), .reset(reset), .load_use(load_use), .redirect(redirect),
    .mc_start(mc_start), .pc_en(a_pc_en), .if_id_en(a_if_id_en),
    .if_id_flush(a_if_id_flush), .id_ex_en(a_id_ex_en), .id_ex_flush(a_id_ex_flush),
    .ex_mem_en(a_ex_mem_en), .ex_mem_flush(a_ex_mem_flush), .mem_wb_en(a_mem_wb_en),
    .mc_busy(a_mc_busy), .stall_cnt(a_stall_cnt)
  );

  pipe_hazard_ctrl #(.MC_LATENCY(LAT_B), .CNT_W(1), .STALL_CNT_W(W_B)) dut_b (
    .clk(clk), .reset(reset), .load_use(load_use), .redirect(redirect),
    .mc_start(mc_start), .pc_en(b_pc_en), .if_id_en(b_if_id_en),
    .if_id_flush(b_if_id_flush), .id_ex_en(b_id_ex_en), .id_ex_flush(b_id_ex_flush),
    .ex_mem_en(b_ex_mem_en), .ex_mem_flush(b_ex_mem_flush), .mem_wb_en(b_mem_wb_en),
    .mc_busy(b_mc_busy), .stall_cnt(b_stall_cnt)
  );

  // Bit order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //            ex_mem_en, ex_mem_flush, mem_wb_en, mc_busy
  function automatic logic [8:0] expect_out(input int lat, input int left,
                                            input logic rst, input logic lu,
                                            input logic rd, input logic mc);
    logic busy;
    if (rst) return 9'b0_1_1_1_1_1_1_1_0;
    if (left > 1) return 9'b0_0_0_0_0_1_1_1_1;
    busy = (left == 1);
    if (rd) return {8'b1_1_1_1_1_1_0_1, busy};
    if (left == 0 && mc && lat > 1) return 9'b0_0_0_0_0_1_1_1_0;
    if (lu) return {8'b0_0_0_1_1_1_0_1, busy};
    return {8'b1_1_0_1_0_1_0_1, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_tick(input int lat, input int w, input logic pc,
                            inout int left, inout int stall);
    if (reset) begin
      left  = 0;
      stall = 0;
    end else begin
      if (!pc && stall < (1 << w) - 1) stall++;
      if (left > 1) left--;
      else if (left == 1) left = 0;
      else if (!redirect && mc_start && lat > 1) left = lat - 1;
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs and the stall
  // counter against the model, then advance the model across the edge.
  task automatic step(input string tag, input logic rst, input logic lu,
                      input logic rd, input logic mc);
    logic [8:0] ea, eb;
    @(negedge clk);
    reset = rst; load_use = lu; redirect = rd; mc_start = mc;
    #1;
    ea = expect_out(LAT_A, a_left, rst, lu, rd, mc);
    eb = expect_out(LAT_B, b_left, rst, lu, rd, mc);
    chk({tag, "_a_out"}, 32'({a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_en, a_id_ex_flush,
                             a_ex_mem_en, a_ex_mem_flush, a_mem_wb_en, a_mc_busy}), 32'(ea));
    chk({tag, "_a_stall"}, 32'(a_stall_cnt), 32'(a_stall));
    chk({tag, "_b_out"}, 32'({b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_flush,
                             b_ex_mem_en, b_ex_mem_flush, b_mem_wb_en, b_mc_busy}), 32'(eb));
    chk({tag, "_b_stall"}, 32'(b_stall_cnt), 32'(b_stall));
    @(posedge clk);
    model_tick(LAT_A, W_A, ea[8], a_left, a_stall);
    model_tick(LAT_B, W_B, eb[8], b_left, b_stall);
  endtask

  initial begin
    reset = 1'b1; load_use = 1'b0; redirect = 1'b0; mc_start = 1'b0;

    // Reset held two cycles, then defaults
    step("rst0", 1, 0, 0, 0);
    step("rst1", 1, 0, 0, 0);
    step("idle", 0, 0, 0, 0);
    chk("rst_stall_zero", 32'(a_stall_cnt), 32'd0);

    // Load-use single cycle
    step("lu", 0, 1, 0, 0);
    step("lu_after", 0, 0, 0, 0);
    chk("lu_stall_one", 32'(a_stall_cnt), 32'd1);

    // Redirect wins over load_use and mc_start
    step("rd_lu", 0, 1, 1, 0);
    step("rd_mc", 0, 0, 1, 1);
    step("rd_after", 0, 0, 0, 0);
    chk("rd_stall_same", 32'(a_stall_cnt), 32'd1);

    // Multi-cycle op: start, two hold cycles, release
    step("mc0", 0, 0, 0, 1);
    step("mc1", 0, 0, 1, 1);
    step("mc2", 0, 1, 0, 0);
    step("mc3_rel", 0, 0, 0, 1);
    step("mc_after", 0, 0, 0, 0);
    chk("mc_stall_four", 32'(a_stall_cnt), 32'd4);

    // Load-use held through an op: honoured only at release
    step("mclu0", 0, 1, 0, 1);
    step("mclu1", 0, 1, 0, 0);
    step("mclu2", 0, 1, 0, 0);
    step("mclu3_rel", 0, 1, 0, 0);
    step("mclu4", 0, 0, 0, 0);
    chk("mclu_stall_eight", 32'(a_stall_cnt), 32'd8);

    // Reset during an op aborts it
    step("ab0", 0, 0, 0, 1);
    step("ab1_rst", 1, 0, 0, 0);
    step("ab2", 0, 0, 0, 0);
    chk("ab_not_busy", 32'(a_mc_busy), 32'd0);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) step("sat_lu", 0, 1, 0, 0);
    step("sat_hold", 0, 0, 0, 0);
    chk("sat_b_three", 32'(b_stall_cnt), 32'd3);
    chk("sat_a_five", 32'(a_stall_cnt), 32'd5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Drives the enable (stall) and synchronous clear (flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC enable.
- Resolves three hazard sources: load-use hazards, control redirects, and multi-cycle EX operations.
- Sits beside the datapath in the core top level; its outputs connect directly to the en/reset pins of the pipeline registers.

Parameters:
MC_LATENCY, 4, cycles a multi-cycle op occupies EX (>=1; 1 means no stall)
CNT_W, 3, width of latency down-counter; must hold MC_LATENCY-1
STALL_CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high reset
load_use  input  1  instruction in ID depends on a load in EX
redirect  input  1  branch/jump resolved taken in EX; PC being redirected
mc_start  input  1  instruction in EX is multi-cycle, first EX cycle
pc_en  output  1  PC register enable
if_id_en  output  1  IF/ID enable
if_id_flush  output  1  IF/ID synchronous clear (effective only with en=1)
id_ex_en  output  1  ID/EX enable
id_ex_flush  output  1  ID/EX synchronous clear
ex_mem_en  output  1  EX/MEM enable
ex_mem_flush  output  1  EX/MEM synchronous clear
mem_wb_en  output  1  MEM/WB enable
mc_busy  output  1  FSM in MC_BUSY
stall_cnt  output  STALL_CNT_W  count of cycles with pc_en=0

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-high reset (reset). Registered state is FSM {IDLE, MC_BUSY}, cnt[CNT_W], and stall_cnt.
- Reset response: reset=1 forces all *_en=1 and all *_flush=1 combinationally, which clears every pipeline register. pc_en=0. mc_busy=0.
- After reset: state=IDLE, cnt=0, stall_cnt=0.
- Outputs are combinational from state, cnt and inputs (zero-latency). Default: all en=1, all flush=0.
- IDLE priority 1, redirect=1: if_id_flush=1, id_ex_flush=1, pc_en=1. load_use and mc_start are ignored this cycle (the two are mutually exclusive with redirect by construction; the bench checks redirect wins).
- IDLE priority 2, mc_start=1 and MC_LATENCY>1: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_en=1, ex_mem_flush=1 (bubble into MEM), mem_wb_en=1. Next state MC_BUSY, cnt<=MC_LATENCY-1. load_use is ignored.
- mc_start with MC_LATENCY==1: treated as no-op; FSM stays in IDLE.
- IDLE priority 3, load_use=1: pc_en=0, if_id_en=0, id_ex_flush=1 (bubble into EX); EX/MEM and MEM/WB advance.
- MC_BUSY, cnt>1: same stall outputs as the mc_start cycle; cnt<=cnt-1; load_use, redirect and mc_start are ignored.
- MC_BUSY, cnt==1 (release cycle): outputs are computed as in IDLE, except mc_start is ignored (same op). load_use is honoured; next state IDLE.
- Total stall cycles per multi-cycle op: exactly MC_LATENCY-1. The result is captured into EX/MEM on the release cycle.
- stall_cnt: +1 on each cycle with reset=0 and pc_en=0; saturates at all-ones, no wrap.
- Reset mid-operation: reset in MC_BUSY returns to IDLE next cycle and discards cnt.
- Invariant: no output asserts a flush together with en=0 on the same register.

Test Plan:
- Reset: hold reset 2 cycles -> all en=1, all flush=1, pc_en=0; after release outputs default, stall_cnt=0, mc_busy=0.
- Load-use: load_use=1 for 1 cycle -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; next cycle defaults; stall_cnt=1.
- Redirect: redirect=1 with load_use=1 -> if_id_flush=1, id_ex_flush=1, pc_en=1, no stall; stall_cnt unchanged.
- Multi-cycle, MC_LATENCY=4: mc_start pulse at cycle 0 -> pc_en=0 and ex_mem_flush=1 in cycles 0-2, mc_busy=1 in cycles 1-3. Cycle 3 is the release cycle with pc_en=1. stall_cnt=3.
- Release plus load-use: load_use=1 held through the MC op -> ignored cycles 1-2, honoured at release cycle 3 (pc_en=0, id_ex_flush=1, ex_mem_flush=0); cycle 4 defaults; stall_cnt=4.
- Saturation/abort: STALL_CNT_W=2, 5 load-use cycles -> stall_cnt=3 and holds. Separately, reset at cycle 1 of an MC op -> IDLE next cycle, mc_busy=0.
